// File: rtl/mpt_pkg.sv
// Shared constants and types for the MPT-walk memory path.
package mpt_pkg;

    localparam int MPT_NUM_REQ        = 4;
    localparam int MPT_MEM_ADDR_WIDTH = 64;
    localparam int MPT_MEM_DATA_WIDTH = 64;

    typedef logic [$clog2(MPT_NUM_REQ)-1:0] mpt_req_idx_t;

endpackage

// File: rtl/mpt_id_fifo.sv
// In-order FIFO of requester indices; the head names the owner of the next memory response.
module mpt_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_reg != '0);
    assign head_o  = mem[rd_ptr_reg];
    assign count_o = count_reg;

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            if (push_i && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push_i && do_pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mpt_walk_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory read port among walking stages,
// holding a grant locked while memory stalls and routing responses back by issue order.
module mpt_walk_mem_arbiter
    import mpt_pkg::*;
#(
    parameter int NUM_REQ         = MPT_NUM_REQ,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = MPT_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH      = MPT_MEM_DATA_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          mem_req_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    input  logic                          mem_err_i,
    output logic                          proto_err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [IDX_W-1:0]      rr_ptr_reg;
    logic [IDX_W-1:0]      lock_idx_reg;
    logic                  lock_reg;
    logic                  proto_err_reg;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      grant_idx;
    logic                  found;
    logic [IDX_W-1:0]      head_idx;
    logic [CNT_W-1:0]      count;
    logic                  issue;
    logic                  accept;
    logic                  rsp_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping; overridden by a held lock.
    always_comb begin
        scan_idx = rr_ptr_reg;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid_i[IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ)]) begin
                found    = 1'b1;
                scan_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            end
        end
        grant_idx = lock_reg ? lock_idx_reg : scan_idx;
    end

    // Only the registered count gates issue, so a same-cycle pop never frees a slot.
    assign issue    = rst_ni && (|req_valid_i) && (count < CNT_W'(MAX_OUTSTANDING));
    assign accept   = issue && mem_gnt_i;
    assign rsp_fire = rst_ni && mem_rvalid_i && (count != '0);

    assign mem_req_o   = issue;
    assign mem_addr_o  = rst_ni ? addr_arr[grant_idx] : '0;
    assign req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rsp_valid_o = rsp_fire ? (NUM_REQ'(1) << head_idx) : '0;
    assign rsp_data_o  = rst_ni ? mem_rdata_i : '0;
    assign rsp_err_o   = rsp_fire && mem_err_i;
    assign proto_err_o = proto_err_reg;

    mpt_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (grant_idx),
        .pop_i       (rsp_fire),
        .head_o      (head_idx),
        .count_o     (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg    <= '0;
            lock_reg      <= 1'b0;
            lock_idx_reg  <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                lock_reg   <= 1'b0;
            end else if (issue) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= grant_idx;
            end
            if (mem_rvalid_i && (count == '0)) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

endmodule
